// File: rtl/spram_pwr_ctrl.sv
// Power-state controller and access gate in front of one spram_wrap instance.
// Define SPRAM_PWR_DS_EN to enable the SLEEP (ds_req) state and its wake-up path.
module spram_pwr_ctrl #(
  parameter int unsigned IDLE_LS = 16,
  parameter int unsigned IDLE_DS = 256,
  parameter int unsigned WAKE_DS = 4,
  parameter int unsigned WAKE_LS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_be,
  input  logic [15:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        sleep_now,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        ls_req,
  output logic        ds_req,
  output logic [2:0]  pwr_state
);

  if (IDLE_LS < 1 || IDLE_LS > 65535 || IDLE_DS < 1 || IDLE_DS > 65535 ||
      WAKE_DS < 1 || WAKE_DS > 65535 || WAKE_LS < 1 || WAKE_LS > 65535) begin : g_param_check
    $error("spram_pwr_ctrl: cycle parameters must be in 1..65535");
  end

  typedef enum logic [2:0] {
    ST_ACTIVE  = 3'd0,
    ST_STBY    = 3'd1,
    ST_SLEEP   = 3'd2,
    ST_WAKE_DS = 3'd3,
    ST_WAKE_LS = 3'd4
  } state_t;

  localparam logic [15:0] LS_LAST  = 16'(IDLE_LS - 1);
  localparam logic [15:0] WLS_LAST = 16'(WAKE_LS - 1);
`ifdef SPRAM_PWR_DS_EN
  localparam logic [15:0] DS_LAST  = 16'(IDLE_DS - 1);
  localparam logic [15:0] WDS_LAST = 16'(WAKE_DS - 1);
  localparam state_t      DEEP_ST  = ST_SLEEP;
`else
  localparam state_t      DEEP_ST  = ST_STBY;
`endif

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        ls_nxt;

  // Handshake: a request is taken on the rising edge where cpu_req=1 and
  // cpu_ready=1; cpu_req and its payload must stay stable until then.
  assign cpu_ready = (state == ST_ACTIVE);
  assign mem_sel   = cpu_req & cpu_ready;
  assign mem_we    = cpu_we & mem_sel;
  assign mem_be    = cpu_be & {4{mem_sel}};
  assign mem_addr  = cpu_addr;
  assign mem_din   = cpu_wdata;
  assign cpu_rdata = mem_dout;
  assign pwr_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    case (state)
      ST_ACTIVE: begin
        if (cpu_req)            cnt_nxt   = 16'd0;
        else if (sleep_now)     state_nxt = DEEP_ST;
        else if (cnt == LS_LAST) state_nxt = ST_STBY;
      end
      ST_STBY: begin
        if (cpu_req) state_nxt = ST_WAKE_LS;
`ifdef SPRAM_PWR_DS_EN
        else if (cnt == DS_LAST || sleep_now) state_nxt = ST_SLEEP;
`endif
      end
`ifdef SPRAM_PWR_DS_EN
      ST_SLEEP: begin
        if (cpu_req) state_nxt = ST_WAKE_DS;
      end
      ST_WAKE_DS: begin
        if (cnt == WDS_LAST) state_nxt = ST_WAKE_LS;
      end
`endif
      ST_WAKE_LS: begin
        if (cnt == WLS_LAST) state_nxt = ST_ACTIVE;
      end
      default: state_nxt = ST_ACTIVE;
    endcase
    // Every state change restarts the shared counter.
    if (state_nxt != state) cnt_nxt = 16'd0;
    ls_nxt = (state_nxt == ST_STBY) || (state_nxt == ST_SLEEP) ||
             (state_nxt == ST_WAKE_DS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACTIVE;
      cnt        <= 16'd0;
      ls_req     <= 1'b0;
      cpu_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ls_req     <= ls_nxt;
      cpu_rvalid <= mem_sel & ~cpu_we;
    end
  end

`ifdef SPRAM_PWR_DS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds_req <= 1'b0;
    else        ds_req <= (state_nxt == ST_SLEEP);
  end
`else
  assign ds_req = 1'b0;
`endif

endmodule

// File: tb/tb_spram_pwr_ctrl.sv
// Directed bench for spram_pwr_ctrl with a behavioural SPRAM and a read-data scoreboard.
module tb_spram_pwr_ctrl;

  localparam int unsigned IDLE_LS = 16;
  localparam int unsigned IDLE_DS = 8;
  localparam int unsigned WAKE_DS = 4;
  localparam int unsigned WAKE_LS = 2;
`ifdef SPRAM_PWR_DS_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        sleep_now;
  logic        mem_sel;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [15:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        ls_req;
  logic        ds_req;
  logic [2:0]  pwr_state;

  int checks;
  int errors;
  int bad_ds;
  int bad_state;
  int waits;
  logic [31:0] exp_q[$];
  logic [31:0] ram [0:255];

  spram_pwr_ctrl #(
    .IDLE_LS(IDLE_LS), .IDLE_DS(IDLE_DS), .WAKE_DS(WAKE_DS), .WAKE_LS(WAKE_LS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .sleep_now(sleep_now),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .ls_req(ls_req), .ds_req(ds_req), .pwr_state(pwr_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Behavioural SPRAM: byte-masked write, one-cycle registered read
  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= ram[mem_addr[7:0]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid=1 expected rvalid=0");
        end else begin
          check("rdata", cpu_rdata, exp_q.pop_front());
        end
      end
      if (ds_req && !DS_EN) bad_ds++;
      if (!DS_EN && !(pwr_state inside {3'd0, 3'd1, 3'd4})) bad_state++;
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_access(input logic we, input logic [3:0] be, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           output int nwait);
    cpu_we    = we;
    cpu_be    = be;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    nwait     = 0;
    while (!cpu_ready && nwait < 100) begin
      step(1);
      nwait++;
    end
    if (!cpu_ready) begin
      check("access_timeout", 32'(cpu_ready), 32'd1);
    end else begin
      if (!we) exp_q.push_back(exp_rd);
      step(1);
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; bad_ds = 0; bad_state = 0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
    cpu_addr = 16'h0; cpu_wdata = 32'h0; sleep_now = 1'b0;
    step(2);
    check("reset_pwr_state", 32'(pwr_state), 32'd0);
    check("reset_ready", 32'(cpu_ready), 32'd1);
    check("reset_ls", 32'(ls_req), 32'd0);
    check("reset_ds", 32'(ds_req), 32'd0);
    check("reset_rvalid", 32'(cpu_rvalid), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Write then read back, plus a partial byte-mask write
    do_access(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 32'h0, waits);
    check("write_wait", 32'(waits), 32'd0);
    do_access(1'b0, 4'hF, 16'h0010, 32'h0, 32'hDEADBEEF, waits);
    check("read_wait", 32'(waits), 32'd0);
    check("read_latency_rvalid", 32'(cpu_rvalid), 32'd1);
    do_access(1'b1, 4'h5, 16'h0010, 32'h11223344, 32'h0, waits);
    do_access(1'b0, 4'hF, 16'h0010, 32'h0, 32'hDE22BE44, waits);
    check("be_read_rvalid", 32'(cpu_rvalid), 32'd1);

    // Idle entry into STBY exactly IDLE_LS edges after the last accept
    step(IDLE_LS - 1);
    check("idle_pre_ls", 32'(ls_req), 32'd0);
    check("idle_pre_state", 32'(pwr_state), 32'd0);
    step(1);
    check("idle_ls", 32'(ls_req), 32'd1);
    check("idle_state_stby", 32'(pwr_state), 32'd1);
    step(3);
    do_access(1'b0, 4'hF, 16'h0010, 32'h0, 32'hDE22BE44, waits);
    check("stby_wake_wait", 32'(waits), 32'(WAKE_LS + 1));
    check("after_wake_ls", 32'(ls_req), 32'd0);

    // sleep_now pulse while idle, then sleep_now together with a request
    sleep_now = 1'b1;
    step(1);
    sleep_now = 1'b0;
    check("sleep_now_state", 32'(pwr_state), DS_EN ? 32'd2 : 32'd1);
    check("sleep_now_ls", 32'(ls_req), 32'd1);
    check("sleep_now_ds", 32'(ds_req), 32'(DS_EN));
    do_access(1'b0, 4'hF, 16'h0010, 32'h0, 32'hDE22BE44, waits);
    check("deep_wake_wait", 32'(waits), DS_EN ? 32'(WAKE_DS + WAKE_LS + 1) : 32'(WAKE_LS + 1));
    sleep_now = 1'b1;
    do_access(1'b0, 4'hF, 16'h0010, 32'h0, 32'hDE22BE44, waits);
    sleep_now = 1'b0;
    check("sleep_req_wait", 32'(waits), 32'd0);
    check("sleep_req_state", 32'(pwr_state), 32'd0);

    // Request dropped mid-wake: wake completes, idle count restarts from 0
    sleep_now = 1'b1;
    step(1);
    sleep_now = 1'b0;
    cpu_req = 1'b1;
    step(1);
    cpu_req = 1'b0;
    check("drop_first_wake_state", 32'(pwr_state), DS_EN ? 32'd3 : 32'd4);
    check("drop_first_wake_ds", 32'(ds_req), 32'd0);
    step(DS_EN ? WAKE_DS : 0);
    check("drop_wake_ls_state", 32'(pwr_state), 32'd4);
    check("drop_wake_ls", 32'(ls_req), 32'd0);
    check("drop_wake_ready", 32'(cpu_ready), 32'd0);
    step(WAKE_LS);
    check("drop_wake_active", 32'(pwr_state), 32'd0);
    step(IDLE_LS - 1);
    check("restart_pre_stby", 32'(pwr_state), 32'd0);
    step(1);
    check("restart_stby", 32'(pwr_state), 32'd1);

`ifdef SPRAM_PWR_DS_EN
    // STBY to SLEEP after IDLE_DS idle cycles, then start a wake
    step(IDLE_DS - 1);
    check("pre_sleep_ds", 32'(ds_req), 32'd0);
    step(1);
    check("sleep_state", 32'(pwr_state), 32'd2);
    check("sleep_ds", 32'(ds_req), 32'd1);
    cpu_req = 1'b1;
    step(1);
    check("wake_ds_state", 32'(pwr_state), 32'd3);
`endif

    // Asynchronous reset while ls_req is high
    check("pre_reset_ls", 32'(ls_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ls", 32'(ls_req), 32'd0);
    check("async_reset_ds", 32'(ds_req), 32'd0);
    check("async_reset_state", 32'(pwr_state), 32'd0);
    cpu_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // Long idle with sleep_now toggling
    for (int i = 0; i < 1000; i++) begin
      sleep_now = (i % 3 == 0);
      step(1);
    end
    sleep_now = 1'b0;
    check("long_idle_state", 32'(pwr_state), DS_EN ? 32'd2 : 32'd1);
    do_access(1'b0, 4'hF, 16'h0010, 32'h0, 32'hDE22BE44, waits);
    check("long_idle_wake_wait", 32'(waits), DS_EN ? 32'(WAKE_DS + WAKE_LS + 1) : 32'(WAKE_LS + 1));
    step(3);

`ifndef SPRAM_PWR_DS_EN
    check("ds_never_high", 32'(bad_ds), 32'd0);
    check("state_values", 32'(bad_state), 32'd0);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
